// File: rtl/id_stage_pkg.sv
// Shared widths, field positions and the ID/EX control bundle for the decode stage.
// The control struct lets a pipeline bubble be written as a single zero assignment.
package id_stage_pkg;

    localparam int N        = 32;
    localparam int N_REG    = 32;
    localparam int N_ALU_OP = 2;
    localparam int IMM_W    = 16;

    localparam int RS_IDX = 25;
    localparam int RT_IDX = 20;
    localparam int RD_IDX = 15;

    // Field order matches the decoder's control outputs, MSB first.
    typedef struct packed {
        logic                alu_src;
        logic [N_ALU_OP-1:0] alu_op;
        logic                reg_dest;
        logic                branch;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_stage_hazard_reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 hardwired to 0.
// Build with WB_BYPASS_EN defined to forward same-cycle write-back data to the read ports.
module reg_file #(
    parameter int N     = 32,
    parameter int N_REG = 32,
    parameter int RW    = $clog2(N_REG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [RW-1:0] raddr_1,
    input  logic [RW-1:0] raddr_2,
    output logic [N-1:0]  rdata_1,
    output logic [N-1:0]  rdata_2
);

    logic [N-1:0] regs [N_REG];
    logic         wr_en;

    assign wr_en = we && (waddr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // The bypass only applies to non-zero indices because wr_en already excludes r0.
    always_comb begin
        rdata_1 = (raddr_1 == '0) ? '0 : regs[raddr_1];
`ifdef WB_BYPASS_EN
        if (wr_en && (waddr == raddr_1)) begin
            rdata_1 = wdata;
        end
`endif
    end

    always_comb begin
        rdata_2 = (raddr_2 == '0) ? '0 : regs[raddr_2];
`ifdef WB_BYPASS_EN
        if (wr_en && (waddr == raddr_2)) begin
            rdata_2 = wdata;
        end
`endif
    end

endmodule

// File: rtl/id_stage_hazard.sv
// Decode stage with register file, immediate extender, load-use hazard detector and ID/EX register.
// Optional macro WB_BYPASS_EN enables same-cycle write-back bypass in the register file.
module id_stage_hazard #(
    parameter  int N        = id_stage_pkg::N,
    parameter  int N_REG    = id_stage_pkg::N_REG,
    parameter  int N_ALU_OP = id_stage_pkg::N_ALU_OP,
    parameter  int IMM_W    = id_stage_pkg::IMM_W,
    parameter  int RS_IDX   = id_stage_pkg::RS_IDX,
    parameter  int RT_IDX   = id_stage_pkg::RT_IDX,
    parameter  int RD_IDX   = id_stage_pkg::RD_IDX,
    localparam int RW       = $clog2(N_REG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        instruction,
    input  logic [N-1:0]        pc_in,
    input  logic                valid_id,
    input  logic                stall_ext,
    input  logic                flush,
    input  logic                imm_zext,
    input  logic                reg_write_wb,
    input  logic [RW-1:0]       write_reg_wb,
    input  logic [N-1:0]        write_data_wb,
    input  logic                alu_src,
    input  logic                reg_dest,
    input  logic                branch,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                mem_to_reg,
    input  logic                reg_write,
    input  logic [N_ALU_OP-1:0] alu_op,
    output logic [N-1:0]        pc_out,
    output logic [N-1:0]        read_data_1,
    output logic [N-1:0]        read_data_2,
    output logic [N-1:0]        imm_ex,
    output logic [RW-1:0]       rs,
    output logic [RW-1:0]       rt,
    output logic [RW-1:0]       rd,
    output logic                alu_src_ex,
    output logic                reg_dest_ex,
    output logic                branch_ex,
    output logic                mem_read_ex,
    output logic                mem_write_ex,
    output logic                mem_to_reg_ex,
    output logic                reg_write_ex,
    output logic [N_ALU_OP-1:0] alu_op_ex,
    output logic                valid_ex,
    output logic                hazard_stall
);

    import id_stage_pkg::*;

    logic [RW-1:0]    rs_field;
    logic [RW-1:0]    rt_field;
    logic [RW-1:0]    rd_field;
    logic [IMM_W-1:0] imm_field;
    logic [N-1:0]     imm_ext;
    logic [N-1:0]     rdata_1;
    logic [N-1:0]     rdata_2;
    ctrl_t            ctrl_id;
    ctrl_t            ctrl_ex;
    logic             load_bubble;

    assign rs_field  = instruction[RS_IDX -: RW];
    assign rt_field  = instruction[RT_IDX -: RW];
    assign rd_field  = instruction[RD_IDX -: RW];
    assign imm_field = instruction[IMM_W-1:0];

    // Opcode bits above the rs field are decoded upstream and not needed here.
    generate
        if (RS_IDX + 1 < N) begin : g_unused_opcode
            logic unused_opcode_bits;
            assign unused_opcode_bits = ^instruction[N-1:RS_IDX+1];
        end
    endgenerate

    assign imm_ext = imm_zext ? {{(N-IMM_W){1'b0}}, imm_field}
                              : {{(N-IMM_W){imm_field[IMM_W-1]}}, imm_field};

    assign ctrl_id = {alu_src, alu_op, reg_dest, branch,
                      mem_read, mem_write, mem_to_reg, reg_write};

    reg_file #(
        .N     (N),
        .N_REG (N_REG),
        .RW    (RW)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .we      (reg_write_wb),
        .waddr   (write_reg_wb),
        .wdata   (write_data_wb),
        .raddr_1 (rs_field),
        .raddr_2 (rt_field),
        .rdata_1 (rdata_1),
        .rdata_2 (rdata_2)
    );

    // The rt comparison is deliberately conservative: it fires even when the consumer ignores rt.
    always_comb begin
        hazard_stall = valid_ex && ctrl_ex.mem_read && (rt != '0) && valid_id &&
                       ((rt == rs_field) || (rt == rt_field));
    end

    assign load_bubble = flush || (!stall_ext && hazard_stall);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out      <= '0;
            read_data_1 <= '0;
            read_data_2 <= '0;
            imm_ex      <= '0;
            rs          <= '0;
            rt          <= '0;
            rd          <= '0;
            ctrl_ex     <= CTRL_NONE;
            valid_ex    <= 1'b0;
        end else if (load_bubble) begin
            pc_out      <= '0;
            read_data_1 <= '0;
            read_data_2 <= '0;
            imm_ex      <= '0;
            rs          <= '0;
            rt          <= '0;
            rd          <= '0;
            ctrl_ex     <= CTRL_NONE;
            valid_ex    <= 1'b0;
        end else if (!stall_ext) begin
            pc_out      <= pc_in;
            read_data_1 <= rdata_1;
            read_data_2 <= rdata_2;
            imm_ex      <= imm_ext;
            rs          <= rs_field;
            rt          <= rt_field;
            rd          <= rd_field;
            ctrl_ex     <= valid_id ? ctrl_id : CTRL_NONE;
            valid_ex    <= valid_id;
        end
    end

    assign alu_src_ex    = ctrl_ex.alu_src;
    assign alu_op_ex     = ctrl_ex.alu_op;
    assign reg_dest_ex   = ctrl_ex.reg_dest;
    assign branch_ex     = ctrl_ex.branch;
    assign mem_read_ex   = ctrl_ex.mem_read;
    assign mem_write_ex  = ctrl_ex.mem_write;
    assign mem_to_reg_ex = ctrl_ex.mem_to_reg;
    assign reg_write_ex  = ctrl_ex.reg_write;

endmodule
